dgldpc_shuffled_vnu_pipe: RTL
=============================

# dgldpc_shuffled_vnu_pipe

Parametrised, pipelined variable-node unit for the shuffled DG-LDPC decoder. It takes DEG sign-magnitude check-to-variable messages and one channel LLR per transaction. It returns DEG scaled extrinsic variable-to-check messages, one a-posteriori value and a hard decision. Degree, widths and scaling mode are configurable; it adds a valid/ready handshake, output saturation and a saturation-event counter, and sits between the CNU message memory and the VN→CN write-back path.

## Interface
- DEG, 4, variable-node degree (number of incoming check messages), ≥2
- MW, 6, input message width, sign-magnitude (MSB = sign)
- LW, 8, channel LLR width, two's complement
- OW, 9, output message width, sign-magnitude
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input transaction valid
- o_ready  out  1  block accepts input this cycle
- i_data  in  [0:DEG-1][MW-1:0]  check messages, sign-magnitude
- i_llr  in  LW  channel LLR, two's complement
- i_mode  in  2  scaling: 0 = ×0.75, 1 = ×1, 2 = ×0.5, 3 = ×1 (reserved)
- o_valid  out  1  output transaction valid
- i_ready  in  1  downstream accepts output
- o_data  out  [0:DEG][OW-1:0]  slots 0..DEG-1 extrinsic, slot DEG a-posteriori, sign-magnitude
- o_hard  out  1  hard decision = sign of a-posteriori value (1 = negative)
- o_sat_cnt  out  16  count of output transactions with any saturated slot

## Operation
- SM→two's complement is exact; negative zero (sign 1, magnitude 0) is treated as 0.
- total T = Σ m_i, signed width TW = MW+$clog2(DEG)+1. Extrinsic e_i = T − m_i, width TW+1. Slot DEG uses T.
- Scaling uses arithmetic shifts with floor on each term: ×0.75 = (x>>>1)+(x>>>2); ×0.5 = x>>>1; ×1 = x.
- r_j = scale(x_j) + sign-extended i_llr, computed at width max(TW+1, LW)+1 with no intermediate overflow.
- Saturation: |r_j| > 2^(OW-1)−1 clamps magnitude to 2^(OW-1)−1 with the sign kept. Conversion to SM never emits negative zero; zero is all-zeros.
- o_hard = 1 iff a-posteriori r_DEG < 0 (r_DEG = 0 → 0).
- o_sat_cnt increments by 1 per output handshake (o_valid & i_ready) with ≥1 saturated slot. It holds at 16'hFFFF.
- i_mode is sampled with the data at input acceptance and travels with it; mid-stream mode changes affect only later transactions.

## Timing
- 3-stage pipeline: S1 registers two's-complement inputs, LLR and mode; S2 registers T and all e_i; S3 registers saturated SM outputs, o_hard and the saturation flag.
- Latency: input accepted at edge n → o_valid high after edge n+2 (third register), throughput 1 per cycle.
- Global enable en = i_ready | ~v3. All stages shift on en. o_ready = en (combinational). Internal bubbles are not collapsed.
- Input handshake: i_valid & o_ready. Output handshake: o_valid & i_ready. o_data and o_hard are stable while o_valid & ~i_ready.
- Reset (async, any time, including mid-stream): stage valids 0, o_valid 0, o_data all 0, o_hard 0, o_sat_cnt 0. In-flight data is discarded. o_ready = 1 while out of reset with an empty pipe.
- A simultaneous saturated output handshake and counter at FFFF leaves the counter at FFFF.

## Structure
- Package dgldpc_vnu_pkg: scale-mode enum (SCALE_075, SCALE_1, SCALE_05, SCALE_RSV), functions sm2tc and scale.
- Sub-module dgldpc_vnu_sat_sm: parametrised saturate and two's-complement→SM with saturation flag. S3 holds DEG+1 instances.

## Test plan
- Defaults, mode 0, i_data all 6'h05, i_llr +10 → 3 cycles later o_data[0..3]=9'h014, o_data[4]=9'h019, o_hard=0, o_sat_cnt=0.
- Mode 1, i_data={6'h23,6'h03,6'h23,6'h03}, i_llr −4 → o_data={9'h101,9'h107,9'h101,9'h107}, o_data[4]=9'h104, o_hard=1.
- Negative zero: mode 1, i_data all 6'h20, i_llr 0 → all slots 9'h000 (never 9'h100), o_hard=0.
- OW=7, mode 1, i_data all 6'h1F, i_llr +127 → all slots 7'h3F; o_sat_cnt 0→1. With the counter preloaded via 65 535 such transactions, the next one leaves it at 16'hFFFF.
- Backpressure: 6 back-to-back inputs, i_ready low for 5 cycles after the first output → o_ready drops once S3 is full, no loss or reorder, held output stable; mode switched 0→2 at input 4 → only outputs 4–6 use ×0.5 (−3 → −2).
- Reset asserted with 3 transactions in flight → o_valid 0 immediately (async), o_sat_cnt 0, and no stale output after release.

Source files
------------

// File: rtl/dgldpc_vnu_pkg.sv
// Shared types and arithmetic helpers for the shuffled DG-LDPC variable-node unit.
package dgldpc_vnu_pkg;

   typedef enum logic [1:0] {
      SCALE_075 = 2'd0,
      SCALE_1   = 2'd1,
      SCALE_05  = 2'd2,
      SCALE_RSV = 2'd3
   } scale_mode_e;

   // Working width for the helpers; callers cast to their own field widths.
   localparam int unsigned FW = 32;

   // Sign-magnitude of width w to two's complement; negative zero folds to 0.
   function automatic logic signed [FW-1:0] sm2tc(input logic [FW-1:0] sm, input int unsigned w);
      logic [FW-1:0] sbit;
      logic [FW-1:0] mag;
      sbit = FW'(1) << (w - 1);
      mag  = sm & (sbit - FW'(1));
      return ((sm & sbit) != '0) ? -$signed(mag) : $signed(mag);
   endfunction

   // Arithmetic-shift scaling, each shifted term floors on its own.
   function automatic logic signed [FW-1:0] scale(input logic signed [FW-1:0] x, input scale_mode_e m);
      case (m)
         SCALE_075: return (x >>> 1) + (x >>> 2);
         SCALE_05:  return x >>> 1;
         default:   return x;
      endcase
   endfunction

endpackage

// File: rtl/dgldpc_vnu_sat_sm.sv
// Clamp a two's-complement value to OW-bit sign-magnitude and flag saturation.
module dgldpc_vnu_sat_sm
   import dgldpc_vnu_pkg::*;
#(
   parameter int unsigned IW = 11,
   parameter int unsigned OW = 9
) (
   input  logic signed [IW-1:0] x,
   output logic        [OW-1:0] sm_c,
   output logic                 sat_c
);

   localparam logic [IW-1:0] MAXM = IW'((1 << (OW - 1)) - 1);

   logic [IW-1:0] mag;

   // Zero magnitude always yields all-zeros, so negative zero never leaves.
   always_comb begin
      mag   = x[IW-1] ? $unsigned(-x) : $unsigned(x);
      sat_c = (mag > MAXM);
      sm_c  = '0;
      if (sat_c)
         sm_c = {x[IW-1], {(OW-1){1'b1}}};
      else if (mag != '0)
         sm_c = {x[IW-1], mag[OW-2:0]};
   end

endmodule

// File: rtl/dgldpc_shuffled_vnu_pipe.sv
// Three-stage variable-node unit: SM->TC capture, total/extrinsic, scale+LLR+saturate.
module dgldpc_shuffled_vnu_pipe
   import dgldpc_vnu_pkg::*;
#(
   parameter int unsigned DEG = 4,
   parameter int unsigned MW  = 6,
   parameter int unsigned LW  = 8,
   parameter int unsigned OW  = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [0:DEG-1][MW-1:0]    i_data,
   input  logic [LW-1:0]             i_llr,
   input  logic [1:0]                i_mode,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [0:DEG][OW-1:0]      o_data,
   output logic                      o_hard,
   output logic [15:0]               o_sat_cnt
);

   localparam int unsigned TW = MW + $clog2(DEG) + 1;
   localparam int unsigned EW = TW + 1;
   localparam int unsigned RW = ((EW > LW) ? EW : LW) + 1;

   logic                 en;
   logic                 v1, v2, sat3;
   logic signed [MW-1:0] m1 [DEG];
   logic signed [LW-1:0] llr1, llr2;
   scale_mode_e          mode1, mode2;
   logic signed [TW-1:0] tot_c, t2;
   logic signed [EW-1:0] e_c [DEG];
   logic signed [EW-1:0] e2 [DEG];
   logic signed [RW-1:0] r_c [DEG+1];
   logic [OW-1:0]        sm_c [DEG+1];
   logic [DEG:0]         sat_c;

   // Whole pipe stalls only when the output register is full and blocked.
   assign en      = i_ready | ~o_valid;
   assign o_ready = en;

   always_comb begin
      tot_c = '0;
      for (int i = 0; i < DEG; i++) tot_c = tot_c + TW'(m1[i]);
      for (int i = 0; i < DEG; i++) e_c[i] = EW'(tot_c) - EW'(m1[i]);
   end

   always_comb begin
      for (int j = 0; j < DEG; j++)
         r_c[j] = RW'(scale(FW'(e2[j]), mode2)) + RW'(llr2);
      r_c[DEG] = RW'(scale(FW'(t2), mode2)) + RW'(llr2);
   end

   for (genvar j = 0; j <= DEG; j++) begin : g_sat
      dgldpc_vnu_sat_sm #(.IW(RW), .OW(OW)) u_sat (
         .x    (r_c[j]),
         .sm_c (sm_c[j]),
         .sat_c(sat_c[j])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         o_valid   <= 1'b0;
         llr1      <= '0;
         llr2      <= '0;
         mode1     <= SCALE_075;
         mode2     <= SCALE_075;
         t2        <= '0;
         sat3      <= 1'b0;
         o_hard    <= 1'b0;
         o_sat_cnt <= '0;
         o_data    <= '0;
         for (int i = 0; i < DEG; i++) begin
            m1[i] <= '0;
            e2[i] <= '0;
         end
      end else begin
         if (o_valid && i_ready && sat3 && (o_sat_cnt != 16'hFFFF))
            o_sat_cnt <= o_sat_cnt + 16'd1;
         if (en) begin
            v1    <= i_valid;
            llr1  <= i_llr;
            mode1 <= scale_mode_e'(i_mode);
            for (int i = 0; i < DEG; i++) m1[i] <= MW'(sm2tc(FW'(i_data[i]), MW));
            v2    <= v1;
            llr2  <= llr1;
            mode2 <= mode1;
            t2    <= tot_c;
            for (int i = 0; i < DEG; i++) e2[i] <= e_c[i];
            o_valid <= v2;
            sat3    <= |sat_c;
            o_hard  <= r_c[DEG][RW-1];
            for (int j = 0; j <= DEG; j++) o_data[j] <= sm_c[j];
         end
      end
   end

endmodule
